// File: rtl/deswitch_write_arbiter_pkg.sv
// Shared constants and helpers for the register-bank write arbiter.
// Default sizing, write counter width and the one-hot decoder used for ack and reg_en.
package deswitch_arb_pkg;

    localparam int unsigned DEF_NREQ   = 4;
    localparam int unsigned DEF_NREG   = 8;
    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned WCOUNT_W   = 8;
    localparam int unsigned ONEHOT_MAX = 32;

    // Callers slice the low bits they need; NREQ and NREG never exceed ONEHOT_MAX.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
        logic [ONEHOT_MAX-1:0] v;
        v = {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/deswitch_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting at ptr and wrapping modulo NREQ; reports the first set bit.
module rr_pick
    import deswitch_arb_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] winner
);

    int unsigned w_idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_idx  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_idx = (32'(ptr) + i) % NREQ;
            if (!valid && req[w_idx]) begin
                valid  = 1'b1;
                winner = PTR_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/deswitch_write_arbiter.sv
// Round-robin arbiter sharing the write port of an enable-gated register bank.
// All outputs are registered; ptr rotates past each winner so it becomes lowest priority.
module deswitch_write_arbiter
    import deswitch_arb_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned NREG  = DEF_NREG,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*$clog2(NREG)-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          ack,
    output logic [NREG-1:0]          reg_en,
    output logic [WIDTH-1:0]         reg_d,
    output logic                     busy,
    output logic [WCOUNT_W-1:0]      write_count
);

    localparam int unsigned ADDR_W = $clog2(NREG);
    localparam int unsigned PTR_W  = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]      r_ptr;
    logic [NREQ-1:0]       r_ack;
    logic [NREG-1:0]       r_reg_en;
    logic [WIDTH-1:0]      r_reg_d;
    logic                  r_busy;
    logic [WCOUNT_W-1:0]   r_count;

    logic                  w_valid;
    logic [PTR_W-1:0]      w_winner;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [ADDR_W-1:0]     w_addr;
    logic [WIDTH-1:0]      w_data;
    logic [ONEHOT_MAX-1:0] w_ack_oh;
    logic [ONEHOT_MAX-1:0] w_en_oh;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .valid  (w_valid),
        .winner (w_winner)
    );

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_winner == PTR_W'(i)) begin
                w_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ack_oh  = onehot(32'(w_winner));
    assign w_en_oh   = onehot(32'(w_addr));
    assign w_ptr_nxt = (w_winner == PTR_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_ack    <= '0;
            r_reg_en <= '0;
            r_reg_d  <= '0;
            r_busy   <= 1'b0;
            r_count  <= '0;
        end else if (w_valid) begin
            r_ptr    <= w_ptr_nxt;
            r_ack    <= w_ack_oh[NREQ-1:0];
            r_reg_en <= w_en_oh[NREG-1:0];
            r_reg_d  <= w_data;
            r_busy   <= 1'b1;
            r_count  <= r_count + 1'b1;
        end else begin
            // Idle edge: reg_d, ptr and the count keep their last values.
            r_ack    <= '0;
            r_reg_en <= '0;
            r_busy   <= 1'b0;
        end
    end

    assign ack         = r_ack;
    assign reg_en      = r_reg_en;
    assign reg_d       = r_reg_d;
    assign busy        = r_busy;
    assign write_count = r_count;

endmodule

// File: tb/tb_deswitch_write_arbiter.sv
// Self-checking bench for deswitch_write_arbiter (NREQ=4, NREG=8, WIDTH=8).
// Table rows and hand sequences push expectations to a scoreboard popped after each edge.
module tb_deswitch_write_arbiter;

    localparam int NREQ = 4, NREG = 8, WIDTH = 8, AW = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic [NREG-1:0]       reg_en;
    logic [WIDTH-1:0]      reg_d;
    logic                  busy;
    logic [7:0]            write_count;

    deswitch_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .ack         (ack),
        .reg_en      (reg_en),
        .reg_d       (reg_d),
        .busy        (busy),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    // Bank of enable-gated D registers fed by the arbiter.
    logic [WIDTH-1:0] bank [NREG];
    initial for (int i = 0; i < NREG; i++) bank[i] = '0;
    always @(posedge clk)
        for (int i = 0; i < NREG; i++)
            if (reg_en[i]) bank[i] <= reg_d;

    typedef struct {
        logic [NREQ-1:0]  ack;
        logic [NREG-1:0]  en;
        logic [WIDTH-1:0] d;
        logic             busy;
        logic [7:0]       cnt;
    } exp_t;

    typedef struct {
        logic [NREQ-1:0] req;
        exp_t            e;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".ack"},  32'(ack),         32'(e.ack));
        chk({tag, ".en"},   32'(reg_en),      32'(e.en));
        chk({tag, ".d"},    32'(reg_d),       32'(e.d));
        chk({tag, ".busy"}, 32'(busy),        32'(e.busy));
        chk({tag, ".cnt"},  32'(write_count), 32'(e.cnt));
    endtask

    // Drive req, queue the expectation, take one edge, then pop and compare.
    task automatic apply(input string tag, input logic [NREQ-1:0] r, input exp_t e);
        exp_t got;
        req = r;
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s.sb: got empty scoreboard expected an entry", tag);
        end else begin
            got = sb.pop_front();
            check_outputs(tag, got);
        end
    endtask

    function automatic exp_t mk(logic [NREQ-1:0] a, logic [NREG-1:0] en,
                                logic [WIDTH-1:0] d, logic b, logic [7:0] c);
        exp_t e;
        e.ack = a; e.en = en; e.d = d; e.busy = b; e.cnt = c;
        return e;
    endfunction

    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Requesters 0..3 target registers 0,3,6,7 with data 11,22,33,44.
        tbl[0]  = '{4'b1111, mk(4'b0001, 8'h01, 8'h11, 1, 8'd1)};
        tbl[1]  = '{4'b1111, mk(4'b0010, 8'h08, 8'h22, 1, 8'd2)};
        tbl[2]  = '{4'b1111, mk(4'b0100, 8'h40, 8'h33, 1, 8'd3)};
        tbl[3]  = '{4'b1111, mk(4'b1000, 8'h80, 8'h44, 1, 8'd4)};
        tbl[4]  = '{4'b1111, mk(4'b0001, 8'h01, 8'h11, 1, 8'd5)};
        tbl[5]  = '{4'b0010, mk(4'b0010, 8'h08, 8'h22, 1, 8'd6)};
        tbl[6]  = '{4'b1010, mk(4'b1000, 8'h80, 8'h44, 1, 8'd7)};
        tbl[7]  = '{4'b1010, mk(4'b0010, 8'h08, 8'h22, 1, 8'd8)};
        tbl[8]  = '{4'b0000, mk(4'b0000, 8'h00, 8'h22, 0, 8'd8)};
        tbl[9]  = '{4'b0101, mk(4'b0100, 8'h40, 8'h33, 1, 8'd9)};
        tbl[10] = '{4'b0001, mk(4'b0001, 8'h01, 8'h11, 1, 8'd10)};

        // Reset state, asynchronous: checked before any clock edge.
        reset = 1'b1; req = '0; req_addr = '0; req_data = '0;
        #2;
        check_outputs("rst", mk(0, 0, 0, 0, 0));
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) apply("idle", 4'b0000, mk(0, 0, 0, 0, 0));

        // Single write to register 5, then verify the bank captured it.
        req_addr = 12'(3'd5) << (2*AW);
        req_data = 32'(8'hA5) << (2*WIDTH);
        apply("single", 4'b0100, mk(4'b0100, 8'h20, 8'hA5, 1, 8'd1));
        apply("single_drop", 4'b0000, mk(0, 0, 8'hA5, 0, 8'd1));
        chk("bank5", 32'(bank[5]), 32'h0000_00A5);

        reset = 1'b1; #2 reset = 1'b0;
        req_addr = {3'd7, 3'd6, 3'd3, 3'd0};
        req_data = 32'h4433_2211;
        for (int i = 0; i < 11; i++) apply($sformatf("tbl%0d", i), tbl[i].req, tbl[i].e);

        // Reset during an ack cycle: outputs drop before the next edge and the write is lost.
        req_data = 32'h4433_225A;
        apply("pre_rst", 4'b0001, mk(4'b0001, 8'h01, 8'h5A, 1, 8'd11));
        #1 reset = 1'b1;
        #1;
        check_outputs("mid_rst", mk(0, 0, 0, 0, 0));
        @(posedge clk); #1;
        chk("bank0_uncommitted", 32'(bank[0]), 32'h0000_0011);
        reset = 1'b0;
        apply("post_rst", 4'b1001, mk(4'b0001, 8'h01, 8'h5A, 1, 8'd1));

        // Counter wrap: 257 back-to-back grants to requester 0 at register 2.
        reset = 1'b1; #2 reset = 1'b0;
        req_addr = 12'(3'd2);
        for (int i = 0; i < 257; i++) begin
            req_data = 32'(8'(i));
            apply($sformatf("wrap%0d", i), 4'b0001,
                  mk(4'b0001, 8'h04, 8'(i), 1, 8'((i + 1) % 256)));
        end
        chk("wrap_final", 32'(write_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
